// File: rtl/vga_pattern_gen_if.sv
// Control inputs and video outputs of the VGA test-pattern generator.
// The generator connects through the slave modport; the pattern source/sink uses master.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4
);
    logic [1:0]           MODE;
    logic [3*COLOR_W-1:0] SOLID_RGB;
    logic                 VGA_HSYNC;
    logic                 VGA_VSYNC;
    logic [COLOR_W-1:0]   VGA_R;
    logic [COLOR_W-1:0]   VGA_G;
    logic [COLOR_W-1:0]   VGA_B;
    logic                 ACTIVE;
    logic [9:0]           COL;
    logic [9:0]           ROW;
    logic                 FRAME_START;

    modport master (
        output MODE, SOLID_RGB,
        input  VGA_HSYNC, VGA_VSYNC, VGA_R, VGA_G, VGA_B, ACTIVE, COL, ROW, FRAME_START
    );

    modport slave (
        input  MODE, SOLID_RGB,
        output VGA_HSYNC, VGA_VSYNC, VGA_R, VGA_G, VGA_B, ACTIVE, COL, ROW, FRAME_START
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four test patterns (solid, bars, checker, bouncing box).
// Every output is registered one cycle behind the column/row counters.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int COLOR_W  = 4,
    parameter int BOX_SIZE = 32
) (
    input  logic              FPGA_CLK,
    input  logic              FPGA_RST_N,
    vga_pattern_gen_if.slave  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int RGB_W   = 3 * COLOR_W;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  BX_MAX  = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  BY_MAX  = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] BOX     = 11'(BOX_SIZE);
    localparam logic        POL     = 1'(SYNC_POL);

    logic [9:0]       col_cnt, row_cnt;
    logic [1:0]       mode_q;
    logic [RGB_W-1:0] solid_q;
    logic [9:0]       bx, by;
    logic             dx, dy;

    logic             at_origin, col_wrap, frame_wrap;
    logic [1:0]       mode_eff;
    logic [RGB_W-1:0] solid_eff;
    logic [10:0]      col_x, row_x;
    logic             hs_c, vs_c, act_c, in_box;
    logic [2:0]       bar;
    logic [RGB_W-1:0] rgb_c;
    logic [10:0]      bx_step, by_step;

    // One bounce step on one axis: returns {new_dir_up, new_pos}.
    function automatic logic [10:0] axis_step(input logic [9:0] p, input logic up,
                                              input logic [9:0] pmax);
        logic [9:0] np;
        logic       nd;
        nd = up;
        np = p;
        if (up) begin
            if (p == pmax) begin
                nd = 1'b0;
                if (p != 10'd0) np = p - 10'd1;
            end else begin
                np = p + 10'd1;
            end
        end else begin
            if (p == 10'd0) begin
                nd = 1'b1;
                if (p != pmax) np = p + 10'd1;
            end else begin
                np = p - 10'd1;
            end
        end
        return {nd, np};
    endfunction

    assign at_origin  = (col_cnt == 10'd0) && (row_cnt == 10'd0);
    assign col_wrap   = (col_cnt == H_LAST);
    assign frame_wrap = col_wrap && (row_cnt == V_LAST);
    assign col_x      = {1'b0, col_cnt};
    assign row_x      = {1'b0, row_cnt};

    // The origin pixel already uses the freshly sampled controls.
    assign mode_eff  = at_origin ? bus.MODE      : mode_q;
    assign solid_eff = at_origin ? bus.SOLID_RGB : solid_q;

    assign bx_step = axis_step(bx, dx, BX_MAX);
    assign by_step = axis_step(by, dy, BY_MAX);

    always_comb begin
        hs_c   = (col_x >= HS_BEG) && (col_x < HS_END);
        vs_c   = (row_x >= VS_BEG) && (row_x < VS_END);
        act_c  = (col_x < H_ACT) && (row_x < V_ACT);
        in_box = (col_x >= {1'b0, bx}) && (col_x < {1'b0, bx} + BOX) &&
                 (row_x >= {1'b0, by}) && (row_x < {1'b0, by} + BOX);
        bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (col_x >= 11'(i * BAR_W)) bar = 3'(i);
        end
        rgb_c = '0;
        case (mode_eff)
            2'd0: rgb_c = solid_eff;
            2'd1: rgb_c = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
            2'd2: rgb_c = {RGB_W{col_cnt[4] ^ row_cnt[4]}};
            default: rgb_c = {RGB_W{in_box}};
        endcase
        if (!act_c) rgb_c = '0;
    end

    always_ff @(posedge FPGA_CLK) begin
        if (!FPGA_RST_N) begin
            col_cnt         <= '0;
            row_cnt         <= '0;
            mode_q          <= '0;
            solid_q         <= '0;
            bx              <= '0;
            by              <= '0;
            dx              <= 1'b1;
            dy              <= 1'b1;
            bus.VGA_HSYNC   <= ~POL;
            bus.VGA_VSYNC   <= ~POL;
            bus.ACTIVE      <= 1'b0;
            bus.COL         <= '0;
            bus.ROW         <= '0;
            bus.FRAME_START <= 1'b0;
            bus.VGA_R       <= '0;
            bus.VGA_G       <= '0;
            bus.VGA_B       <= '0;
        end else begin
            col_cnt <= col_wrap ? 10'd0 : col_cnt + 10'd1;
            if (col_wrap) row_cnt <= (row_cnt == V_LAST) ? 10'd0 : row_cnt + 10'd1;
            if (at_origin) begin
                mode_q  <= bus.MODE;
                solid_q <= bus.SOLID_RGB;
            end
            // Box moves on the wrap edge so the whole next frame sees one position.
            if (frame_wrap) begin
                {dx, bx} <= bx_step;
                {dy, by} <= by_step;
            end
            bus.VGA_HSYNC   <= hs_c ? POL : ~POL;
            bus.VGA_VSYNC   <= vs_c ? POL : ~POL;
            bus.ACTIVE      <= act_c;
            bus.COL         <= col_cnt;
            bus.ROW         <= row_cnt;
            bus.FRAME_START <= at_origin;
            {bus.VGA_R, bus.VGA_G, bus.VGA_B} <= rgb_c;
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Random-stimulus bench: three generators (default timing, small timing, small with
// high-true syncs) compared cycle by cycle against an arithmetic pixel model.
module tb_vga_pattern_gen;
    localparam int SH_A = 24, SH_F = 2, SH_S = 4, SH_B = 2;
    localparam int SV_A = 20, SV_F = 2, SV_S = 2, SV_B = 2;
    localparam int SBOX = 16;
    localparam int FT_DEF = 800 * 525;
    localparam int FT_SML = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [11:0] solid;

    always #5 clk = ~clk;

    vga_pattern_gen_if #(.COLOR_W(4)) if_def();
    vga_pattern_gen_if #(.COLOR_W(4)) if_sml();
    vga_pattern_gen_if #(.COLOR_W(4)) if_pol();

    assign if_def.MODE = mode;  assign if_def.SOLID_RGB = solid;
    assign if_sml.MODE = mode;  assign if_sml.SOLID_RGB = solid;
    assign if_pol.MODE = mode;  assign if_pol.SOLID_RGB = solid;

    vga_pattern_gen u_def (.FPGA_CLK(clk), .FPGA_RST_N(rst_n), .bus(if_def));

    vga_pattern_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .SYNC_POL(0), .COLOR_W(4), .BOX_SIZE(SBOX)
    ) u_sml (.FPGA_CLK(clk), .FPGA_RST_N(rst_n), .bus(if_sml));

    vga_pattern_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .SYNC_POL(1), .COLOR_W(4), .BOX_SIZE(SBOX)
    ) u_pol (.FPGA_CLK(clk), .FPGA_RST_N(rst_n), .bus(if_pol));

    function automatic logic [35:0] obs(input logic hs, vs, act, fs, input logic [9:0] c, r,
                                        input logic [3:0] rr, gg, bb);
        return {hs, vs, act, fs, c, r, rr, gg, bb};
    endfunction

    logic [35:0] o_def, o_sml, o_pol;
    assign o_def = obs(if_def.VGA_HSYNC, if_def.VGA_VSYNC, if_def.ACTIVE, if_def.FRAME_START,
                       if_def.COL, if_def.ROW, if_def.VGA_R, if_def.VGA_G, if_def.VGA_B);
    assign o_sml = obs(if_sml.VGA_HSYNC, if_sml.VGA_VSYNC, if_sml.ACTIVE, if_sml.FRAME_START,
                       if_sml.COL, if_sml.ROW, if_sml.VGA_R, if_sml.VGA_G, if_sml.VGA_B);
    assign o_pol = obs(if_pol.VGA_HSYNC, if_pol.VGA_VSYNC, if_pol.ACTIVE, if_pol.FRAME_START,
                       if_pol.COL, if_pol.ROW, if_pol.VGA_R, if_pol.VGA_G, if_pol.VGA_B);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Box position along one axis: a triangle wave over frames between 0 and m.
    function automatic int tri_pos(input int f, input int m);
        int q;
        if (m <= 0) return 0;
        q = f % (2 * m);
        return (q <= m) ? q : 2 * m - q;
    endfunction

    function automatic logic [35:0] ref_px(input int ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
                                           input int pol, box, k, md,
                                           input logic [11:0] sol, input logic in_rst);
        int ht, vt, ft, f, p, c, r, b, bx, by;
        logic pl, hs, vs, act;
        logic [11:0] rgb;
        pl = (pol != 0);
        if (in_rst) return {~pl, ~pl, 2'b00, 20'd0, 12'd0};
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        ft = ht * vt;
        f = k / ft;
        p = k % ft;
        r = p / ht;
        c = p % ht;
        hs  = (c >= ha + hfp && c < ha + hfp + hsw) ? pl : ~pl;
        vs  = (r >= va + vfp && r < va + vfp + vsw) ? pl : ~pl;
        act = (c < ha) && (r < va);
        bx = tri_pos(f, ha - box);
        by = tri_pos(f, va - box);
        case (md)
            0: rgb = sol;
            1: begin
                b = c / (ha / 8);
                if (b > 7) b = 7;
                rgb = {((b & 4) != 0) ? 4'hF : 4'h0, ((b & 2) != 0) ? 4'hF : 4'h0,
                       ((b & 1) != 0) ? 4'hF : 4'h0};
            end
            2: rgb = ((((c / 16) ^ (r / 16)) & 1) != 0) ? 12'hFFF : 12'h000;
            default: rgb = (c >= bx && c < bx + box && r >= by && r < by + box) ? 12'hFFF : 12'h000;
        endcase
        if (!act) rgb = 12'h000;
        return {hs, vs, act, (p == 0), 10'(c), 10'(r), rgb};
    endfunction

    int          k = 0;
    logic        first_run = 1'b0;
    logic [1:0]  lm_def, lm_sml;
    logic [11:0] ls_def, ls_sml;
    int          hs_first = -1, hs_len = 0, box_px = 0;

    task automatic tick();
        logic [35:0] e_def, e_sml, e_pol;
        int p;
        if (rst_n) begin
            if (k % FT_DEF == 0) begin lm_def = mode; ls_def = solid; end
            if (k % FT_SML == 0) begin lm_sml = mode; ls_sml = solid; end
        end
        e_def = ref_px(640, 16, 96, 48, 480, 10, 2, 33, 0, 32, k, int'(lm_def), ls_def, !rst_n);
        e_sml = ref_px(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 0, SBOX, k,
                       int'(lm_sml), ls_sml, !rst_n);
        e_pol = ref_px(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1, SBOX, k,
                       int'(lm_sml), ls_sml, !rst_n);
        @(posedge clk);
        #1;
        chk(rst_n ? "def_px" : "def_rst", o_def, e_def);
        chk(rst_n ? "sml_px" : "sml_rst", o_sml, e_sml);
        chk(rst_n ? "pol_px" : "pol_rst", o_pol, e_pol);
        if (rst_n) begin
            // Directed looks at line 0 of the default-timing generator in bar mode.
            if (first_run && k < 800) begin
                if (k == 79)  chk("bar79",  {if_def.VGA_R, if_def.VGA_G, if_def.VGA_B}, 12'h000);
                if (k == 80)  chk("bar80",  {if_def.VGA_R, if_def.VGA_G, if_def.VGA_B}, 12'h00F);
                if (k == 639) chk("bar639", {if_def.VGA_R, if_def.VGA_G, if_def.VGA_B}, 12'hFFF);
                if (!if_def.VGA_HSYNC) begin
                    if (hs_first < 0) hs_first = k;
                    hs_len++;
                end
                if (k == 799) begin
                    chk("hs_start", 36'(hs_first), 36'd656);
                    chk("hs_len", 36'(hs_len), 36'd96);
                end
            end
            p = k % FT_SML;
            if (p == 0) box_px = 0;
            if (lm_sml == 2'd3 && if_sml.ACTIVE && {if_sml.VGA_R, if_sml.VGA_G, if_sml.VGA_B} == 12'hFFF)
                box_px++;
            if (p == FT_SML - 1 && lm_sml == 2'd3) chk("box_px", 36'(box_px), 36'd256);
            k++;
        end else begin
            k = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (failures > 40) break;
            if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) solid = 12'($urandom);
            if (k % FT_SML == FT_SML / 2 && (k / FT_SML) % 3 == 0) mode = 2'd3;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 2'd1;
        solid = 12'hF00;
        repeat (3) tick();
        rst_n = 1'b1;
        first_run = 1'b1;
        run(22 * FT_SML + 37);
        first_run = 1'b0;
        // Mid-frame reset, then confirm the frame pulse right after release.
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("fs_after_rst", 36'(if_sml.FRAME_START), 36'd1);
        run(8 * FT_SML);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
